mem_ctrl: RTL and testbench

//   Initiator side of the single-port synchronous RAM interface. Accepts one load/store

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 116 +++++++++++
 tb/tb_mem_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the RAM initiator (mem_ctrl).
// The optional address range check is enabled by defining MEM_CTRL_BOUNDS_EN.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic out_of_range(input logic [31:0] addr, input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request bus plus RAM-side signals of mem_ctrl.
// The master modport is the environment (CPU control unit and RAM); slave is mem_ctrl.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic              ram_read_enable;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        output req, we, addr, wdata, ram_data_out,
        input  ready, done, rdata, err,
        input  ram_address, ram_data_in, ram_write_enable, ram_read_enable
    );

    modport slave (
        input  req, we, addr, wdata, ram_data_out,
        output ready, done, rdata, err,
        output ram_address, ram_data_in, ram_write_enable, ram_read_enable
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-request initiator for a synchronous RAM with 1-cycle read latency.
// Define MEM_CTRL_BOUNDS_EN to reject accesses with addr >= MEM_DEPTH (done+err, no RAM access).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       clear,
    mem_ctrl_if.slave  bus
);

    if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_ctrl: MEM_DEPTH out of range for ADDR_W");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              reject;
    logic              rejected_q;

    assign accept = (state == ST_IDLE) && bus.req;

`ifdef MEM_CTRL_BOUNDS_EN
    assign reject = out_of_range(32'(bus.addr), MEM_DEPTH);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rejected_q <= 1'b0;
        end else if (accept) begin
            rejected_q <= reject;
        end
    end
`else
    assign reject     = 1'b0;
    assign rejected_q = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mar     <= '0;
            mdr     <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                mar <= bus.addr;
                mdr <= bus.wdata;
            end
            if (state == ST_CAPT) begin
                rdata_q <= bus.ram_data_out;
            end
        end
    end

    // NOTE: next-state and output decoders assign defaults first so no latches are inferred.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
                if (bus.req) begin
                    if (reject)      state_nxt = ST_DONE;
                    else if (bus.we) state_nxt = ST_WRITE;
                    else             state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = ST_DONE;
            ST_WRITE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready            = 1'b0;
        bus.done             = 1'b0;
        bus.ram_read_enable  = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.ram_address      = '0;
        bus.ram_data_in      = '0;
        case (state)
            ST_IDLE: bus.ready = 1'b1;
            ST_READ: begin
                bus.ram_read_enable = 1'b1;
                bus.ram_address     = mar;
            end
            ST_WRITE: begin
                bus.ram_write_enable = 1'b1;
                bus.ram_address      = mar;
                bus.ram_data_in      = mdr;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.err   = (state == ST_DONE) && rejected_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl against a transaction-level memory model.
// Build with MEM_CTRL_BOUNDS_EN defined to exercise the range check (MEM_DEPTH=128).
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef MEM_CTRL_BOUNDS_EN
    localparam int DEPTH  = 128;
    localparam bit BOUNDS = 1'b1;
`else
    localparam int DEPTH  = 256;
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic clear;
    logic ram_init;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 8'h54) return 32'h0000_0097;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Synchronous RAM with registered read data; unwritten words read their init_word value.
    logic [DW-1:0] ram       [256];
    logic          ram_valid [256];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram_valid[i] <= 1'b0;
        end else begin
            if (bus.ram_write_enable) begin
                ram[bus.ram_address]       <= bus.ram_data_in;
                ram_valid[bus.ram_address] <= 1'b1;
            end
            if (bus.ram_read_enable)
                bus.ram_data_out <= ram_valid[bus.ram_address] ? ram[bus.ram_address]
                                                               : init_word(bus.ram_address);
        end
    end

    // Reference model: architectural memory contents and last load result.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_rdata;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One request; observes a fixed window of lat+2 cycles after the accept edge.
    task automatic access(input logic is_store, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit perturb, input bit busy);
        int lat;
        int waited = 0;
        int n_re = 0, n_we = 0, n_done = 0, done_at = -1, n_err = 0, n_ready = 0;
        int overlap = 0, bad_addr = 0, bad_data = 0, err_alone = 0;
        bit reject;
        reject = BOUNDS && (int'(a) >= DEPTH);
        lat    = reject ? 1 : (is_store ? 2 : 3);
        while (bus.ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_req", 64'(bus.ready), 64'(1));
        bus.req   = 1'b1;
        bus.we    = is_store;
        bus.addr  = a;
        bus.wdata = d;
        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            if (bus.ram_read_enable) begin
                n_re++;
                if (bus.ram_address !== a) bad_addr++;
            end
            if (bus.ram_write_enable) begin
                n_we++;
                if (bus.ram_address !== a) bad_addr++;
                if (bus.ram_data_in !== d) bad_data++;
            end
            if (bus.ram_read_enable && bus.ram_write_enable) overlap++;
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (bus.err) begin
                n_err++;
                if (!bus.done) err_alone++;
            end
            if (c <= lat && bus.ready) n_ready++;
            bus.req = 1'b0;
            if (c == 1 && perturb) begin
                bus.addr  = '0;
                bus.wdata = '1;
            end
            if (busy && c <= lat) begin
                bus.req   = 1'($urandom_range(0, 1));
                bus.we    = 1'($urandom_range(0, 1));
                bus.addr  = AW'($urandom);
                bus.wdata = $urandom;
            end
        end
        if (!reject) begin
            if (is_store) ref_mem[a] = d;
            else          exp_rdata  = ref_mem[a];
        end
        check("done_latency",   64'(done_at),  64'(lat));
        check("done_count",     64'(n_done),   64'(1));
        check("read_en_cycles", 64'(n_re),     64'((!reject && !is_store) ? 1 : 0));
        check("write_en_cycles",64'(n_we),     64'((!reject && is_store) ? 1 : 0));
        check("enable_overlap", 64'(overlap),  64'(0));
        check("ram_addr_held",  64'(bad_addr), 64'(0));
        check("ram_data_held",  64'(bad_data), 64'(0));
        check("err_pulses",     64'(n_err),    64'(reject ? 1 : 0));
        check("err_with_done",  64'(err_alone),64'(0));
        check("ready_busy",     64'(n_ready),  64'(0));
        check("ready_after",    64'(bus.ready),64'(1));
        check("rdata",          64'(bus.rdata),64'(exp_rdata));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.ready),            64'(1));
        check({tag, "_done"},  64'(bus.done),             64'(0));
        check({tag, "_err"},   64'(bus.err),              64'(0));
        check({tag, "_rdata"}, 64'(bus.rdata),            64'(0));
        check({tag, "_addr"},  64'(bus.ram_address),      64'(0));
        check({tag, "_din"},   64'(bus.ram_data_in),      64'(0));
        check({tag, "_we"},    64'(bus.ram_write_enable), 64'(0));
        check({tag, "_re"},    64'(bus.ram_read_enable),  64'(0));
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] a);
        int n_done = 0;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        @(negedge clk);
        bus.req = 1'b0;
        check("rst_pre_read_en", 64'(bus.ram_read_enable), 64'(1));
        #1 clear = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_rdata = '0;
        @(negedge clk);
        clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("rst_ready_after", 64'(bus.ready), 64'(1));
        check("rst_no_done",     64'(n_done),    64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(AW'(i));
        exp_rdata = '0;
        clear     = 1'b1;
        ram_init  = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        check_reset_outputs("rst_init");
        clear = 1'b0;
        @(negedge clk);

        access(1'b0, 8'h54, '0, 1'b0, 1'b0);
        check("load_54_value", 64'(bus.rdata), 64'(32'h0000_0097));

        reset_mid_read(8'h54);

        access(1'b1, 8'h92, 32'h0000_0046, 1'b0, 1'b0);
        access(1'b0, 8'h92, '0, 1'b0, 1'b0);
        check("load_92_value", 64'(bus.rdata), 64'(32'h0000_0046));

        access(1'b1, 8'h33, 32'hA5A5_5A5A, 1'b1, 1'b0);
        access(1'b0, 8'h33, '0, 1'b1, 1'b0);
        access(1'b0, 8'h10, '0, 1'b0, 1'b1);
        access(1'b1, 8'h11, 32'h1234_5678, 1'b0, 1'b1);

        access(1'b0, 8'h80, '0, 1'b0, 1'b0);
        access(1'b0, 8'h7F, '0, 1'b0, 1'b0);
        access(1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        access(1'b0, 8'hFF, '0, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 8'h7F;
                1:       a = 8'h80;
                2:       a = 8'hFF;
                default: a = AW'($urandom_range(0, 255));
            endcase
            access(1'($urandom_range(0, 1)), a, $urandom,
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
